// File: rtl/mat_pkg.sv
// Shared types and constants for the matrix ALU sequencer slice.
package mat_pkg;

  localparam int unsigned MAT_W  = 256;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned N_REQ  = 2;

  localparam logic [3:0]  MAT_PERIPH  = 4'd3;
  localparam logic [11:0] MAT_REG_A   = 12'h000;
  localparam logic [11:0] MAT_REG_B   = 12'h001;
  localparam logic [11:0] MAT_REG_RES = 12'h002;
  localparam logic [11:0] MAT_REG_CMD = 12'h003;

  typedef enum logic [2:0] {
    OP_MUL44     = 3'd0,
    OP_MUL42     = 3'd1,
    OP_MUL24     = 3'd2,
    OP_ADD       = 3'd3,
    OP_SUB       = 3'd4,
    OP_TRANS     = 3'd5,
    OP_SCALE     = 3'd6,
    OP_SCALE_IMM = 3'd7
  } mat_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_A   = 3'd1,
    S_WR_B   = 3'd2,
    S_WR_OP  = 3'd3,
    S_RD_REQ = 3'd4,
    S_RD_CAP = 3'd5,
    S_REL    = 3'd6,
    S_DONE   = 3'd7
  } seq_state_e;

  // Job state kept after the request transfer; operand A goes straight to the write register.
  typedef struct packed {
    mat_op_e          op;
    logic [MAT_W-1:0] b;
    logic             id;
  } mat_job_t;

endpackage

// File: rtl/mat_alu_sequencer_if.sv
// Requester/response handshake bundle between the requesters and the sequencer.
interface mat_alu_sequencer_if;
  import mat_pkg::*;

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][2:0]       req_op;
  logic [N_REQ-1:0][MAT_W-1:0] req_a;
  logic [N_REQ-1:0][MAT_W-1:0] req_b;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [MAT_W-1:0]            resp_data;
  logic                        resp_id;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );

endinterface

// File: rtl/mat_rr_arbiter.sv
// Two-way round-robin grant decode; the last-grant pointer register lives in the caller.
module mat_rr_arbiter
  import mat_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             last,
  input  logic             update,
  output logic             grant,
  output logic             any_valid,
  output logic             last_next
);

  always_comb begin
    grant = ~last;
    if (req == 2'b01)      grant = 1'b0;
    else if (req == 2'b10) grant = 1'b1;
  end

  assign any_valid = |req;
  assign last_next = update ? grant : last;

endmodule

// File: rtl/mat_alu_sequencer.sv
// Shares the matrix ALU between two requesters: round-robin grant, then the
// write-A / write-B / write-op / read-result bus sequence, result returned by handshake.
module mat_alu_sequencer
  import mat_pkg::*;
#(
  parameter logic [3:0] PERIPH = MAT_PERIPH
) (
  input  logic               clk,
  input  logic               nReset,
  mat_alu_sequencer_if.slave req_if,
  output logic [ADDR_W-1:0]  addr,
  output logic               nWrite,
  output logic               nRead,
  inout  wire  [MAT_W-1:0]   bus
);

  seq_state_e        state_q, state_d;
  mat_job_t          job_q, job_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              nwrite_q, nwrite_d;
  logic              nread_q, nread_d;
  logic [MAT_W-1:0]  wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [MAT_W-1:0]  resp_data_q, resp_data_d;
  logic              resp_id_q, resp_id_d;
  logic              last_q, last_d;
  logic              armed_q;
  logic              grant, any_valid, idle_c, xfer;
  logic [N_REQ-1:0]  req_ready_c;

  mat_rr_arbiter u_arb (
    .req       (req_if.req_valid),
    .last      (last_q),
    .update    (xfer),
    .grant     (grant),
    .any_valid (any_valid),
    .last_next (last_d)
  );

  // Ready is held off until the first edge after reset so nothing transfers during reset.
  assign idle_c      = armed_q && (state_q == S_IDLE);
  assign req_ready_c = {idle_c && grant, idle_c && !grant};
  assign xfer        = any_valid && |(req_ready_c & req_if.req_valid);

  assign req_if.req_ready  = req_ready_c;
  assign req_if.resp_valid = resp_valid_q;
  assign req_if.resp_data  = resp_data_q;
  assign req_if.resp_id    = resp_id_q;
  assign addr              = addr_q;
  assign nWrite            = nwrite_q;
  assign nRead             = nread_q;
  assign bus               = nwrite_q ? {MAT_W{1'bz}} : wdata_q;

  // Next-state and next-output decode; bus-side outputs are computed one state ahead.
  always_comb begin
    state_d      = state_q;
    job_d        = job_q;
    addr_d       = addr_q;
    nwrite_d     = nwrite_q;
    nread_d      = nread_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          state_d  = S_WR_A;
          job_d.op = mat_op_e'(req_if.req_op[grant]);
          job_d.b  = req_if.req_b[grant];
          job_d.id = grant;
          addr_d   = {PERIPH, MAT_REG_A};
          nwrite_d = 1'b0;
          wdata_d  = req_if.req_a[grant];
        end
      end
      S_WR_A: begin
        state_d = S_WR_B;
        addr_d  = {PERIPH, MAT_REG_B};
        wdata_d = job_q.b;
      end
      S_WR_B: begin
        state_d = S_WR_OP;
        addr_d  = {PERIPH, MAT_REG_CMD};
        wdata_d = MAT_W'(job_q.op);
      end
      S_WR_OP: begin
        state_d  = S_RD_REQ;
        addr_d   = {PERIPH, MAT_REG_RES};
        nwrite_d = 1'b1;
        nread_d  = 1'b0;
        wdata_d  = '0;
      end
      S_RD_REQ: state_d = S_RD_CAP;
      S_RD_CAP: begin
        state_d     = S_REL;
        resp_data_d = bus;
        addr_d      = '0;
        nread_d     = 1'b1;
      end
      S_REL: begin
        state_d      = S_DONE;
        resp_valid_d = 1'b1;
        resp_id_d    = job_q.id;
      end
      S_DONE: begin
        if (req_if.resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= S_IDLE;
      job_q        <= '0;
      addr_q       <= '0;
      nwrite_q     <= 1'b1;
      nread_q      <= 1'b1;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      last_q       <= 1'b1;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      job_q        <= job_d;
      addr_q       <= addr_d;
      nwrite_q     <= nwrite_d;
      nread_q      <= nread_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      last_q       <= last_d;
      armed_q      <= 1'b1;
    end
  end

endmodule
